// File: rtl/fetch_ctrl_gen.sv
// Fetch-stage control FSM: drives PC enable/load, PC source and vector
// address select. Supports prioritised maskable interrupts taken only at
// instruction boundaries, variable-length instructions and a RET/RTI
// memory wait.
module fetch_ctrl_gen #(
  parameter int NUM_IRQ  = 4,
  parameter int MAX_EXT  = 3,
  parameter int RET_WAIT = 2,
  parameter int EW_W     = 2,
  parameter int AS_W     = 3,
  parameter int CW       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               int_en,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [EW_W-1:0]    ext_words,
  input  logic               is_jump,
  input  logic               is_ret,
  input  logic               branch_taken,
  input  logic               bypass_done,
  output logic               pc_en,
  output logic               pc_load,
  output logic [1:0]         pc_src,
  output logic [AS_W-1:0]    addr_src,
  output logic               stall,
  output logic               sf1,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic [CW-1:0]      wait_cnt
);

  typedef enum logic [2:0] {RST_VEC, FETCH, EXT, WAIT, BRANCH, IRQ} state_t;

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t             state, state_nxt;
  logic [EW_W-1:0]    ext_cnt, ext_cnt_nxt;
  logic [CW-1:0]      wait_nxt;
  logic [NUM_IRQ-1:0] pend, ack_raw, avail;
  logic [IW-1:0]      irq_idx, irq_idx_nxt;
  logic               pc_was_loaded;
  logic               en_raw, to_fetch, frozen;

  // Lowest set bit wins (index 0 is highest priority).
  function automatic logic [IW-1:0] lowest(input logic [NUM_IRQ-1:0] v);
    lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) lowest = IW'(i);
  endfunction

  // The reset-vector fetch always completes; every other state freezes.
  assign frozen = stall_in && (state != RST_VEC);

  // Next-state, counter updates and output decode.
  always_comb begin
    state_nxt   = state;
    ext_cnt_nxt = ext_cnt;
    wait_nxt    = wait_cnt;
    irq_idx_nxt = irq_idx;
    en_raw      = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 2'b00;
    addr_src    = '0;
    stall       = 1'b0;
    sf1         = 1'b0;
    ack_raw     = '0;
    to_fetch    = 1'b0;
    avail       = '0;
    unique case (state)
      RST_VEC: begin
        en_raw   = 1'b1;
        pc_load  = 1'b1;
        pc_src   = 2'b01;
        addr_src = AS_W'(1);
        to_fetch = 1'b1;
      end
      FETCH: begin
        // PC already points past a freshly loaded target; skip the increment.
        en_raw = !pc_was_loaded;
        if (ext_words != '0) begin
          state_nxt   = EXT;
          ext_cnt_nxt = (ext_words > EW_W'(MAX_EXT)) ? EW_W'(MAX_EXT) : ext_words;
        end else if (branch_taken || is_jump) begin
          state_nxt = BRANCH;
        end else if (is_ret) begin
          state_nxt = WAIT;
        end else begin
          to_fetch = 1'b1;
        end
      end
      EXT: begin
        en_raw = 1'b1;
        if (ext_cnt <= EW_W'(1)) begin
          ext_cnt_nxt = '0;
          to_fetch    = 1'b1;
        end else begin
          ext_cnt_nxt = ext_cnt - 1'b1;
        end
      end
      WAIT: begin
        if (wait_cnt >= CW'(RET_WAIT)) begin
          wait_nxt  = '0;
          state_nxt = BRANCH;
        end else begin
          stall    = 1'b1;
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      BRANCH: begin
        if (branch_taken) begin
          en_raw = 1'b1; pc_load = 1'b1; pc_src = 2'b00; to_fetch = 1'b1;
        end else if (is_ret) begin
          en_raw = 1'b1; pc_load = 1'b1; pc_src = 2'b11; to_fetch = 1'b1;
        end else if (is_jump && bypass_done) begin
          en_raw = 1'b1; pc_load = 1'b1; pc_src = 2'b10; to_fetch = 1'b1;
        end else if (is_jump) begin
          stall = 1'b1;
        end else begin
          to_fetch = 1'b1;
        end
      end
      IRQ: begin
        en_raw           = 1'b1;
        pc_load          = 1'b1;
        pc_src           = 2'b01;
        addr_src         = AS_W'(2) + AS_W'(irq_idx);
        sf1              = 1'b1;
        ack_raw[irq_idx] = 1'b1;
        to_fetch         = 1'b1;
      end
      default: state_nxt = RST_VEC;
    endcase

    // Instruction boundary: a pending enabled line diverts FETCH into IRQ.
    // The line being acknowledged this cycle is no longer a candidate.
    if (to_fetch) begin
      avail = pend & ~ack_raw & irq_mask;
      if (int_en && (avail != '0)) begin
        state_nxt   = IRQ;
        irq_idx_nxt = lowest(avail);
      end else begin
        state_nxt = FETCH;
      end
    end

    if (frozen) begin
      state_nxt   = state;
      ext_cnt_nxt = ext_cnt;
      wait_nxt    = wait_cnt;
      irq_idx_nxt = irq_idx;
    end
  end

  assign pc_en   = en_raw & !frozen;
  assign int_ack = frozen ? '0 : ack_raw;

  // State and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RST_VEC;
      ext_cnt  <= '0;
      wait_cnt <= '0;
      irq_idx  <= '0;
    end else begin
      state    <= state_nxt;
      ext_cnt  <= ext_cnt_nxt;
      wait_cnt <= wait_nxt;
      irq_idx  <= irq_idx_nxt;
    end
  end

  // Sticky pending latch; an ack clears only its own bit, a fresh request wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= (pend & ~int_ack) | (irq & irq_mask);
  end

  // Remembers that the last PC write was a load, so FETCH skips one increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 pc_was_loaded <= 1'b1;
    else if (pc_en && pc_load) pc_was_loaded <= 1'b1;
    else if (!stall_in)        pc_was_loaded <= 1'b0;
  end

endmodule
